hd_pipe_arbiter: RTL

Round-robin arbiter that shares one fixed-latency pipelined datapath between NREQ requesters. The datapath takes one op per cycle and has a fixed latency. The arbiter grants at most one requester per cycle and issues that op into the datapath. A valid/tag delay line, a shift register of depth LATENCY, tracks each op in flight and reports its completion back to the requester that issued it.

---
 rtl/hd_pipe_arbiter_if.sv | 33 +++
 rtl/hd_pipe_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/hd_pipe_arbiter_if.sv
// Requester-side bundle for the pipelined-datapath arbiter.
// Combinational: gnt/issue are same-cycle from req/en; done/inflight come from registers.
// No backpressure: a requester holds req until it sees its gnt bit.
interface hd_pipe_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
);
  localparam int TAG_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic             en;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic [NREQ-1:0]  done;
  logic [CNT_W-1:0] inflight;
  logic             idle;

  // Requester / environment side.
  modport master (
    output en, req,
    input  gnt, issue_valid, issue_tag, done_valid, done_tag, done, inflight, idle
  );

  // Arbiter side.
  modport slave (
    input  en, req,
    output gnt, issue_valid, issue_tag, done_valid, done_tag, done, inflight, idle
  );
endinterface

// File: rtl/hd_pipe_arbiter.sv
// Round-robin arbiter issuing one op per cycle into a fixed-latency datapath.
// Grant is combinational; completion reported exactly LATENCY cycles after issue.
// Ungranted requests wait with req held; the datapath itself never stalls.
module hd_pipe_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  hd_pipe_arbiter_if.slave   bus
);
  localparam int TAG_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic [NREQ-1:0]    gnt_c;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   scan_idx;
  logic               found;

  // Scan p, p+1, ... wrapping modulo NREQ; the first requester seen wins.
  always_comb begin
    gnt_c     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = TAG_W'((int'(ptr_q) + k) % NREQ);
      if (bus.en && !found && bus.req[scan_idx]) begin
        found           = 1'b1;
        grant_idx       = scan_idx;
        gnt_c[scan_idx] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  // Valid/tag delay line shifts every cycle; idle slots carry tag 0.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = found;
    for (int i = 0; i < LATENCY; i++) begin
      tag_d[i] = '0;
    end
    tag_d[0] = grant_idx;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
  end

  // In-flight count is the population of the next delay-line state.
  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_d = inflight_d + CNT_W'(valid_d[i]);
    end
  end

  // State registers; reset drops every op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      valid_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.issue_valid = found;
  assign bus.issue_tag   = grant_idx;
  assign bus.done_valid  = valid_q[LATENCY-1];
  assign bus.done_tag    = tag_q[LATENCY-1];
  assign bus.done        = valid_q[LATENCY-1] ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_q[LATENCY-1]) : '0;
  assign bus.inflight    = inflight_q;
  assign bus.idle        = (inflight_q == '0) && !found;

endmodule
